// File: rtl/perf_stat_ctrl_pkg.sv
// perf_stat_ctrl_pkg: shared run-state encoding and counter index constants.
package perf_stat_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int CNT_CYCLE  = 0;
    localparam int CNT_JUMP   = 1;
    localparam int CNT_BRANCH = 2;
    localparam int CNT_STALL  = 3;

endpackage

// File: rtl/perf_stat_ctrl_sat_event_counter.sv
// sat_event_counter: saturating event counter with sticky overflow flag.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero value and ovf, wins over inc
//   inc        : increment request
//   value      : current count, holds at all-ones
//   ovf        : set by an increment attempt at all-ones
module sat_event_counter #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc,
    output logic [DATA_BITS-1:0] value,
    output logic                 ovf
);

    logic [DATA_BITS-1:0] value_q;
    logic                 ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else if (inc) begin
            if (&value_q) ovf_q <= 1'b1;
            else          value_q <= value_q + 1'b1;
        end
    end

    assign value = value_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/perf_stat_ctrl.sv
// perf_stat_ctrl: run/halt gated performance counters with registered display read port.
//   start/halt/resume : run-state control (IDLE -> RUN <-> HALTED)
//   clear             : zero counters and overflow flags, state untouched
//   evt_*             : per-cycle event strobes, counted only in RUN
//   auto_scan, rd_sel : timed rotation or manual select of the displayed counter
//   rd_idx, rd_data   : registered index and value of the displayed counter
//   running, halted   : decoded run state
//   ovf               : sticky saturation flags per counter
module perf_stat_ctrl
    import perf_stat_ctrl_pkg::*;
#(
    parameter int DATA_BITS   = 32,
    parameter int SCAN_BITS   = 16,
    parameter int SCAN_PERIOD = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 resume,
    input  logic                 clear,
    input  logic                 evt_jump,
    input  logic                 evt_branch,
    input  logic                 evt_stall,
    input  logic                 auto_scan,
    input  logic [1:0]           rd_sel,
    output logic [1:0]           rd_idx,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 running,
    output logic                 halted,
    output logic [3:0]           ovf
);

    state_e               state_q, state_d;
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [1:0]           rd_idx_q, rd_idx_d;
    logic [DATA_BITS-1:0] rd_data_q;
    logic [3:0]           inc;
    logic [DATA_BITS-1:0] cnt [4];
    logic                 scan_wrap;

    always_comb begin
        state_d = (state_q == IDLE   && start)            ? RUN    :
                  (state_q == RUN    && halt)             ? HALTED :
                  (state_q == HALTED && (resume || start)) ? RUN    : state_q;
    end

    // Counting is gated on the current state, so the halt cycle itself still counts.
    always_comb begin
        inc             = '0;
        inc[CNT_CYCLE]  = state_q == RUN;
        inc[CNT_JUMP]   = state_q == RUN && evt_jump;
        inc[CNT_BRANCH] = state_q == RUN && evt_branch;
        inc[CNT_STALL]  = state_q == RUN && evt_stall;
    end

    genvar i;
    for (i = 0; i < 4; i++) begin : g_cnt
        sat_event_counter #(.DATA_BITS(DATA_BITS)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .inc   (inc[i]),
            .value (cnt[i]),
            .ovf   (ovf[i])
        );
    end

    // Timer sits at 0 while manual, so a rising auto_scan always starts a full period.
    assign scan_wrap = auto_scan && scan_q == SCAN_BITS'(SCAN_PERIOD - 1);

    always_comb begin
        scan_d   = (!auto_scan || scan_wrap) ? '0 : scan_q + 1'b1;
        rd_idx_d = !auto_scan ? rd_sel : scan_wrap ? rd_idx_q + 2'd1 : rd_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scan_q    <= '0;
            rd_idx_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            scan_q    <= scan_d;
            rd_idx_q  <= rd_idx_d;
            rd_data_q <= cnt[rd_idx_q];
        end
    end

    assign rd_idx  = rd_idx_q;
    assign rd_data = rd_data_q;
    assign running = state_q == RUN;
    assign halted  = state_q == HALTED;

endmodule

// File: tb/tb_perf_stat_ctrl.sv
// tb_perf_stat_ctrl: directed plus random stimulus against a behavioural model of perf_stat_ctrl.
module tb_perf_stat_ctrl;

    localparam int DB  = 4;
    localparam int SP  = 4;
    localparam int MAX = (1 << DB) - 1;

    logic          clk = 0, rst_n = 0;
    logic          start = 0, halt = 0, resume = 0, clear = 0;
    logic          evt_jump = 0, evt_branch = 0, evt_stall = 0, auto_scan = 0;
    logic [1:0]    rd_sel = 0;
    logic [1:0]    rd_idx;
    logic [DB-1:0] rd_data;
    logic          running, halted;
    logic [3:0]    ovf;

    perf_stat_ctrl #(.DATA_BITS(DB), .SCAN_BITS(3), .SCAN_PERIOD(SP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .resume(resume),
        .clear(clear), .evt_jump(evt_jump), .evt_branch(evt_branch),
        .evt_stall(evt_stall), .auto_scan(auto_scan), .rd_sel(rd_sel),
        .rd_idx(rd_idx), .rd_data(rd_data), .running(running), .halted(halted), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    int m_cnt [4];
    bit m_ovf [4];
    bit m_run, m_halted;
    int m_idx, m_data, m_timer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 0;
        end
        m_run = 0; m_halted = 0; m_idx = 0; m_data = 0; m_timer = 0;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] ovf_exp;
        for (int k = 0; k < 4; k++) ovf_exp[k] = m_ovf[k];
        chk({tag, ".running"}, running, m_run);
        chk({tag, ".halted"}, halted, m_halted);
        chk({tag, ".rd_idx"}, rd_idx, m_idx);
        chk({tag, ".rd_data"}, rd_data, m_data);
        chk({tag, ".ovf"}, ovf, ovf_exp);
    endtask

    // Advance the model by one clock using the inputs currently applied, then compare.
    task automatic tick(input string tag = "cyc");
        bit ev [4];
        int nxt_cnt [4];
        bit nxt_ovf [4];
        bit n_run, n_halted;
        int n_idx, n_timer;
        ev[0] = 1; ev[1] = evt_jump; ev[2] = evt_branch; ev[3] = evt_stall;
        for (int k = 0; k < 4; k++) begin
            nxt_cnt[k] = m_cnt[k];
            nxt_ovf[k] = m_ovf[k];
            if (clear) begin
                nxt_cnt[k] = 0;
                nxt_ovf[k] = 0;
            end else if (m_run && ev[k]) begin
                if (m_cnt[k] == MAX) nxt_ovf[k] = 1;
                else nxt_cnt[k] = m_cnt[k] + 1;
            end
        end
        n_run = m_run; n_halted = m_halted;
        if (!m_run && !m_halted) n_run = start;
        else if (m_run && halt) begin n_run = 0; n_halted = 1; end
        else if (m_halted && (resume || start)) begin n_run = 1; n_halted = 0; end
        n_idx = m_idx; n_timer = m_timer;
        if (!auto_scan) begin
            n_idx = rd_sel;
            n_timer = 0;
        end else begin
            n_timer = m_timer + 1;
            if (n_timer == SP) begin
                n_timer = 0;
                n_idx = (m_idx + 1) % 4;
            end
        end
        @(posedge clk);
        m_data = m_cnt[m_idx];
        m_cnt = nxt_cnt; m_ovf = nxt_ovf;
        m_run = n_run; m_halted = n_halted;
        m_idx = n_idx; m_timer = n_timer;
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int base;
        m_reset();
        #12 rst_n = 1;
        @(negedge clk);
        check_all("reset");

        start = 1; tick("start"); start = 0;
        repeat (10) tick("run");
        halt = 1; tick("halt"); halt = 0;
        chk("halt.halted", halted, 1);
        tick(); tick();
        chk("halt.cnt0", rd_data, 11);
        repeat (3) tick("halted");
        chk("halt.cnt0_frozen", rd_data, 11);

        resume = 1; tick("resume"); resume = 0;
        repeat (3) begin evt_jump = 1; tick("jump"); evt_jump = 0; tick(); end
        repeat (2) begin evt_branch = 1; tick("br"); evt_branch = 0; tick(); end
        repeat (5) begin evt_stall = 1; tick("stall"); evt_stall = 0; tick(); end
        rd_sel = 1; tick(); tick(); chk("sel.jump", rd_data, 3);
        rd_sel = 2; tick(); tick(); chk("sel.branch", rd_data, 2);
        rd_sel = 3; tick(); tick(); chk("sel.stall", rd_data, 5);

        rd_sel = 0; repeat (20) tick("sat");
        chk("sat.cnt0", rd_data, MAX);
        chk("sat.ovf0", ovf[0], 1);
        repeat (3) tick("sat_hold");
        chk("sat.ovf0_sticky", ovf[0], 1);

        clear = 1; evt_jump = 1; tick("clear"); clear = 0; evt_jump = 0;
        chk("clear.ovf", ovf, 0);
        chk("clear.running", running, 1);
        tick("post_clear");
        chk("clear.rd0", rd_data, 0);
        tick("post_clear");
        chk("clear.rd1", rd_data, 1);

        base = rd_idx;
        auto_scan = 1;
        for (int s = 1; s <= 5; s++) begin
            repeat (SP - 1) tick("scan_wait");
            chk("scan.hold", rd_idx, (base + s - 1) % 4);
            tick("scan_step");
            chk("scan.step", rd_idx, (base + s) % 4);
        end
        auto_scan = 0; rd_sel = 2; tick("scan_off");
        chk("scan.manual", rd_idx, 2);

        repeat (400) begin
            evt_jump   = $urandom_range(0, 1);
            evt_branch = $urandom_range(0, 1);
            evt_stall  = $urandom_range(0, 1);
            start      = $urandom_range(0, 19) == 0;
            halt       = $urandom_range(0, 15) == 0;
            resume     = $urandom_range(0, 9) == 0;
            clear      = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 3) == 0) rd_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) auto_scan = ~auto_scan;
            tick("rand");
        end
        {evt_jump, evt_branch, evt_stall, start, halt, resume, clear, auto_scan} = '0;

        if (!m_run) begin
            resume = 1; start = 1; tick("rerun"); resume = 0; start = 0;
        end
        evt_jump = 1; evt_stall = 1; repeat (3) tick("prerst");
        chk("prerst.running", running, 1);
        #2 rst_n = 0;
        #1 m_reset();
        check_all("async_rst");
        #1 rst_n = 1;
        @(negedge clk);
        repeat (4) tick("idle_after_rst");
        chk("idle.rd_data", rd_data, 0);
        evt_jump = 0; evt_stall = 0; rd_sel = 0;
        start = 1; tick("restart"); start = 0;
        repeat (4) tick("recount");
        chk("recount.cnt0", rd_data, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perf_stat_ctrl.md
# perf_stat_ctrl

Performance-statistics controller for the pipeline CPU. It owns four event counters:
- total run cycles
- jumps
- taken conditional branches
- load-use stall cycles

It gates them with a run/halt state machine driven by the syscall halt and the front-panel start/resume/clear inputs. It also multiplexes one counter at a time onto a registered read port for the display, either by manual selection or by timed auto-scan.

## Interface
Parameters:
- DATA_BITS, 32, width of each counter and of rd_data
- SCAN_BITS, 16, width of the auto-scan timer
- SCAN_PERIOD, 50000, cycles per auto-scan step (must be ≥2 and ≤2^SCAN_BITS)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  level, IDLE→RUN
- halt  in  1  syscall halt pulse, RUN→HALTED
- resume  in  1  HALTED→RUN
- clear  in  1  zero all counters and overflow flags
- evt_jump  in  1  jump retired this cycle
- evt_branch  in  1  conditional branch taken this cycle
- evt_stall  in  1  load-use stall this cycle
- auto_scan  in  1  1 = timed rotation of rd_idx, 0 = rd_idx follows rd_sel
- rd_sel  in  2  manual counter select (0 cycles, 1 jump, 2 branch, 3 stall)
- rd_idx  out  2  index of counter currently on rd_data
- rd_data  out  DATA_BITS  value of counter rd_idx
- running  out  1  state == RUN
- halted  out  1  state == HALTED
- ovf  out  4  sticky saturation flags, bit i for counter i

## Operation
- FSM states: IDLE, RUN, HALTED.
  - IDLE: start=1 → RUN.
  - RUN: halt=1 → HALTED; resume is ignored.
  - HALTED: resume=1 → RUN; start is also accepted as resume.
  - halt is ignored outside RUN.
  - No path returns to IDLE except reset.
- Counting happens only while state == RUN, evaluated on the current state.
  - Counter 0 increments every RUN cycle.
  - Counters 1–3 increment when their event is 1.
  - The cycle in which halt is sampled is still counted. Events arriving in IDLE or HALTED are dropped.
- Saturation: a counter at all-ones holds its value. An increment attempt at all-ones sets ovf[i], which stays set until clear or reset.
- clear is accepted in any state and takes priority over increment in the same cycle. That cycle's events are lost, counters and ovf become 0, and the FSM state is unaffected.
- Read path:
  - auto_scan=0: rd_idx ← rd_sel each cycle.
  - auto_scan=1: the scan timer counts 0..SCAN_PERIOD-1. When it wraps, rd_idx ← rd_idx+1 (mod 4, 3→0).
  - The timer holds at 0 while auto_scan=0 and restarts from 0 when auto_scan rises.
- rd_data ← counter[rd_idx] is registered and reflects post-update counter values one cycle later.

## Timing
- Reset values:
  - state IDLE, all counters 0, ovf 0
  - rd_idx 0, rd_data 0, scan timer 0
  - running 0, halted 0
- running and halted are decoded from registered state, so they change the cycle after the triggering input.
- Event to counter: 1 cycle. Counter to rd_data: +1 cycle, so an event at edge N is visible on rd_data at edge N+2 when that counter is selected.
- rd_sel change to rd_data: 2 cycles (rd_idx at +1, rd_data at +2).
- Auto-scan: rd_idx advances exactly once every SCAN_PERIOD cycles.
- If rst_n is asserted mid-run, all state clears immediately (asynchronously), with no completion of in-flight increments.

## Structure
- A shared package holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, HALTED=2'd2)
  - counter index constants (CNT_CYCLE=0, CNT_JUMP=1, CNT_BRANCH=2, CNT_STALL=3)
- One sub-module, sat_event_counter, instantiated four times. Its parameter is DATA_BITS; its ports are clk, rst_n, clear, inc, value, and ovf. It provides saturating increment, a sticky ovf flag, and clear priority.
- The FSM, scan timer and read mux stay in the top level.

## Test plan
- Reset, start, run 10 cycles, then halt → counter 0 = 11, running=0 and halted=1 the following cycle, and further cycles do not change counter 0.
- In RUN, pulse evt_jump 3×, evt_branch 2×, evt_stall 5× with auto_scan=0 and rd_sel=1,2,3 in turn → rd_data shows 3, 2, 5, each two cycles after the rd_sel change.
- Assert clear together with evt_jump in RUN → all counters 0, ovf=0, FSM stays RUN, counter 0 = 1 on the next cycle.
- With DATA_BITS=4, run 20 cycles → counter 0 holds 15, ovf[0]=1, and ovf[0] stays 1 until clear.
- With SCAN_PERIOD=4 and auto_scan=1 → rd_idx follows 0,1,2,3,0 with steps 4 cycles apart. Dropping auto_scan with rd_sel=2 gives rd_idx=2 the next cycle.
- Assert rst_n low for part of a cycle mid-RUN with nonzero counters → all outputs read 0 and state is IDLE, and start is required to resume counting.
